mskpresent_round_ctrl: RTL and testbench

Round sequencer for the masked PRESENT-80 core: drives the enable and select lines of the masked state and key registers, counts the 31 rounds, waits out the latency of the masked HPC S-box layer each round, and presents an input/output valid-ready handshake to the surrounding wrapper. It carries only control signals and never touches shares.

---
 rtl/mskpresent_round_ctrl_if.sv | 29 ++
 rtl/mskpresent_round_ctrl.sv | 116 +++++++++++
 tb/tb_mskpresent_round_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mskpresent_round_ctrl_if.sv
// rtl/mskpresent_round_ctrl_if.sv - job and randomness handshakes of the masked PRESENT-80 round controller
interface mskpresent_round_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic rnd_valid;
  logic rnd_ready;

  // Wrapper side: offers jobs, consumes results, supplies randomness
  modport master (
    output in_valid,
    output out_ready,
    output rnd_valid,
    input  in_ready,
    input  out_valid,
    input  rnd_ready
  );

  // Controller side
  modport slave (
    input  in_valid,
    input  out_ready,
    input  rnd_valid,
    output in_ready,
    output out_valid,
    output rnd_ready
  );
endinterface

// File: rtl/mskpresent_round_ctrl.sv
// rtl/mskpresent_round_ctrl.sv - round sequencer for the masked PRESENT-80 core (optional MSKPRESENT_CTRL_RND_STALL_EN)
module mskpresent_round_ctrl #(
  parameter int NROUNDS  = 31,
  parameter int SBOX_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mskpresent_round_ctrl_if.slave hs,
  output logic                   state_en_o,
  output logic                   state_load_o,
  output logic                   key_en_o,
  output logic                   key_load_o,
  output logic                   sbox_en_o,
  output logic [4:0]             round_cnt_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SBOX = 2'd1,
    UPD  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [3:0] LAT_LAST = 4'(SBOX_LAT - 1);
  localparam logic [4:0] RND_LAST = 5'(NROUNDS);

  state_e     state_q;
  logic [3:0] lat_cnt_q;
  logic [4:0] round_cnt_q;
  logic       out_valid_q;
  logic       busy_q;

  logic       load;
  logic       sbox_go;

  // The load cycle is the handshake cycle itself so the datapath captures
  // the plaintext/key shares while the producer still presents them.
  assign load = (state_q == IDLE) && hs.in_valid;

`ifdef MSKPRESENT_CTRL_RND_STALL_EN
  // Without fresh randomness the gadget pipeline must not advance
  assign sbox_go = (state_q == SBOX) && hs.rnd_valid;
`else
  // PRNG is assumed always valid; rnd_valid is not looked at
  assign sbox_go = (state_q == SBOX);
`endif

  // Round FSM with registered round counter, latency counter and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= 4'd0;
      round_cnt_q <= 5'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs.in_valid) begin
            state_q     <= SBOX;
            round_cnt_q <= 5'd1;
            lat_cnt_q   <= 4'd0;
            busy_q      <= 1'b1;
          end
        end
        SBOX: begin
          if (sbox_go) begin
            if (lat_cnt_q == LAT_LAST) begin
              lat_cnt_q <= 4'd0;
              state_q   <= UPD;
            end else begin
              lat_cnt_q <= lat_cnt_q + 4'd1;
            end
          end
        end
        UPD: begin
          lat_cnt_q <= 4'd0;
          if (round_cnt_q == RND_LAST) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            round_cnt_q <= round_cnt_q + 5'd1;
            state_q     <= SBOX;
          end
        end
        DONE: begin
          if (hs.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Register enables fire only in the load cycle and in UPD
  assign state_en_o   = load || (state_q == UPD);
  assign key_en_o     = load || (state_q == UPD);
  assign state_load_o = load;
  assign key_load_o   = load;
  assign sbox_en_o    = sbox_go;
  assign round_cnt_o  = round_cnt_q;
  assign busy_o       = busy_q;

  assign hs.in_ready  = (state_q == IDLE);
  assign hs.out_valid = out_valid_q;
  assign hs.rnd_ready = sbox_go;

endmodule

// File: tb/tb_mskpresent_round_ctrl.sv
// tb/tb_mskpresent_round_ctrl.sv - directed self-checking bench for mskpresent_round_ctrl
module tb_mskpresent_round_ctrl;

`ifdef MSKPRESENT_CTRL_RND_STALL_EN
  localparam int STALL_EXTRA = 3;
`else
  localparam int STALL_EXTRA = 0;
`endif
  localparam int STALL_FIRST = 13;  // first SBOX cycle of round 5 after the load cycle
  localparam int JOB_CYCLES  = 94;

  logic       clk;
  logic       rst;
  logic       state_en;
  logic       state_load;
  logic       key_en;
  logic       key_load;
  logic       sbox_en;
  logic [4:0] round_cnt;
  logic       busy;

  int n_vec;
  int n_miss;
  int ov_cyc;
  int bp_bad;

  mskpresent_round_ctrl_if hs ();

  mskpresent_round_ctrl #(
    .NROUNDS  (31),
    .SBOX_LAT (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hs           (hs.slave),
    .state_en_o   (state_en),
    .state_load_o (state_load),
    .key_en_o     (key_en),
    .key_load_o   (key_load),
    .sbox_en_o    (sbox_en),
    .round_cnt_o  (round_cnt),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issues a load at the current negedge and follows the job until out_valid
  task automatic run_job(input bit hold_valid, output int ov);
    int exp_rnd;
    int upd_n;
    int olap;
    int stall_bad;
    logic exp_sb;
    exp_rnd   = 1;
    upd_n     = 0;
    olap      = 0;
    stall_bad = 0;
    ov        = -1;
    hs.in_valid = 1'b1;
    #1;
    chk("load_cycle", {27'd0, state_en, key_en, state_load, key_load, sbox_en}, 32'b11110);
    for (int c = 1; c <= 200 && ov < 0; c++) begin
      @(negedge clk);
      if (!hold_valid) hs.in_valid = 1'b0;
      hs.rnd_valid = !(c >= STALL_FIRST && c < STALL_FIRST + 3);
      #1;
      if (state_en && !state_load) begin
        chk("upd_round", {27'd0, round_cnt}, exp_rnd);
        exp_rnd++;
        upd_n++;
      end
      if ((state_en || key_en) && sbox_en) olap++;
      if (c >= STALL_FIRST && c < STALL_FIRST + 3) begin
        exp_sb = (STALL_EXTRA != 0) ? 1'b0 : (c < STALL_FIRST + 2);
        if (sbox_en !== exp_sb || hs.rnd_ready !== exp_sb) stall_bad++;
      end
      if (hs.out_valid) ov = c;
    end
    hs.rnd_valid = 1'b1;
    chk("upd_count", upd_n, 31);
    chk("en_during_sbox", olap, 0);
    chk("stall_window_sbox_en", stall_bad, 0);
    chk("out_valid_cycle", ov, JOB_CYCLES + STALL_EXTRA);
  endtask

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    rst          = 1'b1;
    hs.in_valid  = 1'b0;
    hs.out_ready = 1'b0;
    hs.rnd_valid = 1'b1;

    // Reset state
    #13;
    chk("reset_state",
        {24'd0, hs.in_ready, hs.out_valid, hs.rnd_ready, state_en, key_en, sbox_en, busy, state_load},
        32'b1000_0000);
    chk("reset_round_cnt", {27'd0, round_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single job with out_ready held low
    run_job(1'b0, ov_cyc);

    // Backpressure in DONE for 10 cycles
    bp_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (!hs.out_valid || state_en || key_en || sbox_en || hs.in_ready || busy) bp_bad++;
    end
    chk("backpressure_hold", bp_bad, 0);
    hs.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after_release", {30'd0, hs.in_ready, hs.out_valid}, 32'b10);
    chk("round_held_idle", {27'd0, round_cnt}, 31);

    // Back-to-back: in_valid and out_ready held high throughout
    run_job(1'b1, ov_cyc);
    @(negedge clk);
    #1;
    chk("b2b_second_load", {29'd0, hs.in_ready, state_load, hs.out_valid}, 32'b110);
    chk("b2b_round_held_on_load", {27'd0, round_cnt}, 31);
    @(negedge clk);
    #1;
    chk("b2b_round_restart", {26'd0, busy, round_cnt}, {26'd0, 1'b1, 5'd1});

    // Abort in round 17 with an asynchronous mid-cycle reset
    hs.in_valid = 1'b0;
    for (int i = 0; i < 49; i++) @(negedge clk);
    #1;
    chk("round17_reached", {27'd0, round_cnt}, 17);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_outputs",
        {24'd0, hs.in_ready, hs.out_valid, hs.rnd_ready, state_en, key_en, sbox_en, busy, state_load},
        32'b1000_0000);
    chk("abort_round_cnt", {27'd0, round_cnt}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_release", {31'd0, hs.in_ready}, 1);
    @(negedge clk);

    // Fresh job after the abort
    run_job(1'b0, ov_cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
